// File: rtl/wb_board_io.sv
// rtl/wb_board_io.sv - Wishbone board I/O: LEDs with blink, debounced push-buttons with edge capture and irq.
module wb_board_io #(
  parameter int NUM_LED         = 2,
  parameter int NUM_PB          = 1,
  parameter int DEBOUNCE_CYCLES = 24000,
  parameter int BLINK_DIV       = 6000000,
  parameter bit LED_ACTIVE_LOW  = 1'b0,
  parameter bit PB_ACTIVE_LOW   = 1'b1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [4:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                irq_o,
  output logic [NUM_LED-1:0]  led_o,
  input  logic [NUM_PB-1:0]   pb_i
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_DIV - 1);

  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [NUM_LED-1:0]  led_out_q, led_out_d;
  logic [NUM_LED-1:0]  led_blink_q, led_blink_d;
  logic [NUM_LED-1:0]  led_q, led_d;
  logic [NUM_PB-1:0]   irq_en_q, irq_en_d;
  logic [NUM_PB-1:0]   pb_edge_q, pb_edge_d;
  logic [NUM_PB-1:0]   sync1_q, sync2_q;
  logic [NUM_PB-1:0]   deb_q, deb_d;
  logic [NUM_PB-1:0]   pb_accept, pb_rise, pb_clr;
  logic [PW-1:0]       pre_q, pre_d;
  logic                phase_q, phase_d;
  logic                irq_q, irq_d;

  logic        req, wr;
  logic [2:0]  widx;
  logic [31:0] wmask, rdata;
  logic        unused_adr;

  // A request is blocked in the cycle right after an ack, so a held strobe acks every other cycle.
  assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr         = req & wb_we_i;
  assign widx       = wb_adr_i[4:2];
  assign wmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign unused_adr = ^wb_adr_i[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  always_comb begin
    rdata = '0;
    case (widx)
      3'd0: rdata = 32'(led_out_q);
      3'd1: rdata = 32'(led_blink_q);
      3'd2: rdata = 32'(deb_q);
      3'd3: rdata = 32'(pb_edge_q);
      3'd4: rdata = 32'(irq_en_q);
      3'd5: rdata = {8'h00, 8'(NUM_PB), 8'(NUM_LED), 8'h01};
      default: rdata = '0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_pb
    logic [CW-1:0] cnt_q;
    logic          differ;
    assign differ        = sync2_q[gi] ^ deb_q[gi];
    assign pb_accept[gi] = differ && (cnt_q == CNT_MAX);
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !differ || pb_accept[gi]) cnt_q <= '0;
      else                                      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pb_rise = pb_accept & sync2_q;
  assign pb_clr  = (wr && widx == 3'd3) ? NUM_PB'(wb_dat_i & wmask) : '0;

  always_comb begin
    ack_d       = req;
    dat_d       = req ? rdata : '0;
    led_out_d   = (wr && widx == 3'd0) ? NUM_LED'(merge(32'(led_out_q), wb_dat_i, wmask)) : led_out_q;
    led_blink_d = (wr && widx == 3'd1) ? NUM_LED'(merge(32'(led_blink_q), wb_dat_i, wmask)) : led_blink_q;
    irq_en_d    = (wr && widx == 3'd4) ? NUM_PB'(merge(32'(irq_en_q), wb_dat_i, wmask)) : irq_en_q;
    // A press landing on the same cycle as its W1C must not be lost.
    pb_edge_d   = (pb_edge_q & ~pb_clr) | pb_rise;
    deb_d       = (deb_q & ~pb_accept) | (sync2_q & pb_accept);
    pre_d       = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    phase_d     = phase_q ^ (pre_q == PRE_MAX);
    led_d       = (led_out_q & (~led_blink_q | {NUM_LED{phase_q}})) ^ {NUM_LED{LED_ACTIVE_LOW}};
    irq_d       = |(pb_edge_q & irq_en_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      led_out_q   <= '0;
      led_blink_q <= '0;
      irq_en_q    <= '0;
      pb_edge_q   <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      pre_q       <= '0;
      phase_q     <= 1'b0;
      led_q       <= {NUM_LED{LED_ACTIVE_LOW}};
      irq_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      led_out_q   <= led_out_d;
      led_blink_q <= led_blink_d;
      irq_en_q    <= irq_en_d;
      pb_edge_q   <= pb_edge_d;
      sync1_q     <= pb_i ^ {NUM_PB{PB_ACTIVE_LOW}};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      pre_q       <= pre_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      irq_q       <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;
  assign led_o    = led_q;

endmodule

// File: doc/wb_board_io.md
Name: wb_board_io

Overview:
- Wishbone-slave board I/O peripheral replacing hardwired LED/push-button glue in board top levels.
- Drives NUM_LED user LEDs (static or blinking) and reads NUM_PB push-buttons through synchroniser, debounce and press-edge capture, with a level interrupt.
- Sits on the SoC Wishbone bus in the wb_clk domain; pads connect directly to board pins.

Parameters:
- NUM_LED, 2, number of LED outputs (1..32).
- NUM_PB, 1, number of push-button inputs (1..32).
- DEBOUNCE_CYCLES, 24000, consecutive stable cycles needed to accept a button change (>=2).
- BLINK_DIV, 6000000, wb_clk cycles per blink phase toggle (>=2).
- LED_ACTIVE_LOW, 0, 1 = invert led_o.
- PB_ACTIVE_LOW, 1, 1 = pad low means pressed.

Ports:
- wb_clk_i  in  1  clock; the only clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  5  byte address; bits [4:2] select the register.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- irq_o  out  1  interrupt, level.
- led_o  out  NUM_LED  LED pads.
- pb_i  in  NUM_PB  raw asynchronous button pads.

Behaviour:
- Registers (word index = adr[4:2]); unused upper bits read 0:
  - 0 LED_OUT: RW.
  - 1 LED_BLINK: RW, per-LED blink enable.
  - 2 PB_STATE: RO, debounced state, 1 = pressed.
  - 3 PB_EDGE: R/W1C, latched press events.
  - 4 IRQ_EN: RW, per-button enable.
  - 5 INFO: RO, {8'h0, NUM_PB[7:0], NUM_LED[7:0], 8'h01 version}.
  - 6, 7: read 0; writes ignored.
- Bus transactions:
  - Write honours wb_sel_i per byte.
  - wb_ack_o rises one cycle after cyc&stb is first seen and is held for exactly 1 cycle. No ack in the cycle after an ack; a held strobe therefore gets ack every 2nd cycle.
  - Register update and W1C take effect on the ack cycle.
  - wb_dat_o is valid on the ack cycle and is 0 otherwise.
- Button path, per bit:
  - Raw pad is XORed with PB_ACTIVE_LOW, then passes a 2-flop synchroniser.
  - Counter cnt: cleared when sync == debounced; otherwise increments. When cnt reaches DEBOUNCE_CYCLES-1 while still differing, debounced <= sync and cnt <= 0.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - A 0->1 debounced transition sets PB_EDGE[i] in the same cycle debounced updates.
  - Set and W1C of the same bit in the same cycle: the set wins, so the bit stays 1.
- Blink:
  - Shared prescaler counts 0..BLINK_DIV-1 and wraps. The phase flop toggles on wrap.
  - led_int[i] = LED_OUT[i] & (~LED_BLINK[i] | phase).
  - led_o = led_int ^ {NUM_LED{LED_ACTIVE_LOW}}, registered, so there is 1 cycle latency from register or phase change to pad.
- irq_o = |(PB_EDGE & IRQ_EN), registered; it rises 1 cycle after the edge bit sets.
- Reset values:
  - All registers, synchronisers, counters and phase: 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
  - led_o = all LEDs off (all 1s if LED_ACTIVE_LOW).
  - A reset asserted mid-transaction drops ack and discards the write. Mid-debounce, the counter clears.
  - After reset, a button already held is accepted as a new press after 2 sync cycles + DEBOUNCE_CYCLES, setting PB_EDGE.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_DIV=8, NUM_LED=2, NUM_PB=2, LED_ACTIVE_LOW=0, PB_ACTIVE_LOW=1.
- Reset then read INFO -> 32'h0002_0201. led_o=2'b00, irq_o=0, one ack per access, ack low on the following cycle.
- Write LED_OUT=3, LED_BLINK=2 -> led_o[0]=1 steady. led_o[1] toggles every 8 cycles in step with phase. Write LED_BLINK=0 -> led_o[1]=1 steady 1 cycle after ack.
- Drive pb_i[0] low with a 2-cycle glitch, then release -> PB_STATE stays 0, PB_EDGE=0. Hold low >=6 cycles -> PB_STATE=1, PB_EDGE=1.
- IRQ_EN=1, press pb0 -> irq_o=1 one cycle after PB_EDGE[0] sets. Write PB_EDGE=1 -> irq_o=0. Press pb1 with IRQ_EN[1]=0 -> PB_EDGE=2, irq_o stays 0.
- W1C of PB_EDGE[0] in the same cycle as a new debounced press on pb0 -> PB_EDGE[0] reads 1 afterwards.
- Byte write wb_sel_i=4'b0010, data 32'hFFFF_FFFF to LED_OUT=1 -> LED_OUT unchanged (1). Assert reset during a write strobe -> no ack, registers 0.
